fp_invsqrt_arb: RTL

Round-robin arbiter and response router that shares one bfloat16 inverse-square-root pipeline (`fp_invsqrt_pipe`, fixed latency, no backpressure) among `NUM_REQ` layernorm requesters. It sits between the per-lane layernorm variance stages and the single invsqrt instance. It issues at most one operand per cycle and tags each operand through a delay line matched to the pipe latency. Each result is returned to its originating requester over a valid/ready handshake. Each requester has at most one operation outstanding, so results always have a landing register and the pipe never needs to stall.

---
 rtl/fp_invsqrt_arb_if.sv | 26 ++
 rtl/fp_invsqrt_arb.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fp_invsqrt_arb_if.sv
// Requester/response and invsqrt-pipe signal bundle for fp_invsqrt_arb.
// slave = the arbiter; master = the requesters plus the pipe around it.
interface fp_invsqrt_arb_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_vld;
    logic [NUM_REQ-1:0]    req_rdy;
    logic [16*NUM_REQ-1:0] req_x;
    logic [NUM_REQ-1:0]    rsp_vld;
    logic [NUM_REQ-1:0]    rsp_rdy;
    logic [16*NUM_REQ-1:0] rsp_y;
    logic [15:0]           pipe_x;
    logic                  pipe_x_vld;
    logic [15:0]           pipe_y;
    logic                  pipe_y_vld;

    modport slave (
        input  req_vld, req_x, rsp_rdy, pipe_y, pipe_y_vld,
        output req_rdy, rsp_vld, rsp_y, pipe_x, pipe_x_vld
    );

    modport master (
        output req_vld, req_x, rsp_rdy, pipe_y, pipe_y_vld,
        input  req_rdy, rsp_vld, rsp_y, pipe_x, pipe_x_vld
    );
endinterface

// File: rtl/fp_invsqrt_arb.sv
// Round-robin sharing of one fixed-latency bf16 invsqrt pipe among NUM_REQ requesters.
// Define INVSQRT_ARB_SPECIAL_EN to resolve zero/denormal and negative operands locally.
module fp_invsqrt_arb #(
    parameter int NUM_REQ  = 4,
    parameter int PIPE_LAT = 17
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_invsqrt_arb_if.slave bus,
    output logic            busy,
    output logic            err
);
    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
        logic             spec;
        logic [15:0]      sval;
    } tag_t;

    logic [1:0]            state_q [NUM_REQ];
    logic [IDX_W-1:0]      ptr;
    logic                  grant_any;
    logic [IDX_W-1:0]      grant_idx;
    logic [NUM_REQ-1:0]    grant_oh;
    logic [15:0]           grant_x;
    logic                  grant_spec;
    logic [15:0]           grant_sval;
    logic [15:0]           pipe_x_q;
    logic                  pipe_x_vld_q;
    tag_t                  issue_q;
    tag_t                  tag_q [PIPE_LAT];
    tag_t                  tag_out;
    logic                  land;
    logic [15:0]           land_data;
    logic                  misalign;
    logic [16*NUM_REQ-1:0] rsp_y_q;
    logic [NUM_REQ-1:0]    rsp_vld_c;
    logic                  err_q;

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return IDX_W'((v >= NUM_REQ) ? (v - NUM_REQ) : v);
    endfunction

    // First eligible requester at or above ptr, wrapping around.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!grant_any && bus.req_vld[wrap_idx(int'(ptr) + off)] &&
                state_q[wrap_idx(int'(ptr) + off)] == ST_IDLE) begin
                grant_any = 1'b1;
                grant_idx = wrap_idx(int'(ptr) + off);
            end
        end
        grant_oh = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
        grant_x  = bus.req_x[int'(grant_idx)*16 +: 16];
    end

    always_comb begin
        grant_spec = 1'b0;
        grant_sval = '0;
`ifdef INVSQRT_ARB_SPECIAL_EN
        if (grant_x[14:7] == 8'd0) begin
            grant_spec = 1'b1;
            grant_sval = 16'h7F80;
        end else if (grant_x[15]) begin
            grant_spec = 1'b1;
            grant_sval = 16'h7FC0;
        end
`endif
    end

    // issue_q is the tag entry that travels alongside pipe_x_vld into the delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_x_q     <= '0;
            pipe_x_vld_q <= 1'b0;
            issue_q      <= '0;
            ptr          <= '0;
        end else begin
            pipe_x_vld_q <= grant_any && !grant_spec;
            issue_q      <= '{vld: grant_any, idx: grant_idx, spec: grant_spec, sval: grant_sval};
            if (grant_any && !grant_spec)
                pipe_x_q <= grant_x;
            if (grant_any)
                ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++)
                tag_q[i] <= '0;
        end else begin
            tag_q[0] <= issue_q;
            for (int i = 1; i < PIPE_LAT; i++)
                tag_q[i] <= tag_q[i-1];
        end
    end

    assign tag_out = tag_q[PIPE_LAT-1];

    // A special tag carries its own answer; any pipe result next to it is stray.
    always_comb begin
        land      = 1'b0;
        land_data = '0;
        misalign  = 1'b0;
        if (tag_out.vld && tag_out.spec) begin
            land      = 1'b1;
            land_data = tag_out.sval;
            misalign  = bus.pipe_y_vld;
        end else if (tag_out.vld) begin
            if (bus.pipe_y_vld) begin
                land      = 1'b1;
                land_data = bus.pipe_y;
            end else begin
                misalign  = 1'b1;
            end
        end else begin
            misalign = bus.pipe_y_vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++)
                state_q[i] <= ST_IDLE;
            rsp_y_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (misalign)
                err_q <= 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                case (state_q[i])
                    ST_IDLE: if (grant_oh[i]) state_q[i] <= ST_BUSY;
                    ST_BUSY: begin
                        if (land && int'(tag_out.idx) == i) begin
                            state_q[i]           <= ST_DONE;
                            rsp_y_q[i*16 +: 16]  <= land_data;
                        end
                    end
                    ST_DONE: if (bus.rsp_rdy[i]) state_q[i] <= ST_IDLE;
                    default: state_q[i] <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        rsp_vld_c = '0;
        for (int i = 0; i < NUM_REQ; i++)
            rsp_vld_c[i] = (state_q[i] == ST_DONE);
    end

    always_comb begin
        busy = issue_q.vld;
        for (int i = 0; i < NUM_REQ; i++)
            if (state_q[i] != ST_IDLE) busy = 1'b1;
        for (int i = 0; i < PIPE_LAT; i++)
            if (tag_q[i].vld) busy = 1'b1;
    end

    assign bus.req_rdy    = grant_oh;
    assign bus.rsp_vld    = rsp_vld_c;
    assign bus.rsp_y      = rsp_y_q;
    assign bus.pipe_x     = pipe_x_q;
    assign bus.pipe_x_vld = pipe_x_vld_q;
    assign err            = err_q;
endmodule
